add_serial: RTL and testbench

ADD_SERIAL -- requirements
Module: add_serial

---
 rtl/add_pkg.sv | 13 +
 rtl/FullAdder.sv | 13 +
 rtl/add_slice.sv | 33 +++
 rtl/add_serial.sv | 137 +++++++++++++
 tb/tb_add_serial.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/add_pkg.sv
// Shared types and default sizing for the digit-serial adder/subtractor.
package add_pkg;

    localparam int ADD_WIDTH = 16;
    localparam int ADD_DIGIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/FullAdder.sv
// Single-bit full adder cell used to build the ripple slice.
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/add_slice.sv
// DIGIT-bit ripple-carry slice built from FullAdder cells; also exposes the
// carry into its top bit so the caller can derive signed overflow.
module add_slice
    import add_pkg::*;
#(
    parameter int DIGIT = ADD_DIGIT
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        FullAdder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[DIGIT];
    assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/add_serial.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock, LSB slice
// first, and publishes the full WIDTH-bit result with carry and overflow.
module add_serial
    import add_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int DIGIT = ADD_DIGIT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if (DIGIT < 1 || WIDTH < DIGIT || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("add_serial: WIDTH must be a positive multiple of DIGIT");
    end

    state_t             state;
    state_t             state_nxt;
    logic               load;
    logic               step;

    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   res_sh;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               last;

    logic [DIGIT-1:0]   slice_sum;
    logic               slice_cout;
    logic               slice_cmsb;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]   res_nxt;

    add_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .a    (a_sh[DIGIT-1:0]),
        .b    (b_sh[DIGIT-1:0]),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout),
        .cmsb (slice_cmsb)
    );

    // New slice enters at the top; after N steps the LSB slice sits at bit 0.
    assign res_cat = {slice_sum, res_sh};
    assign res_nxt = res_cat[WIDTH+DIGIT-1:DIGIT];
    assign last    = (cnt == CNT_W'(N - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Subtraction is a + ~b + 1, so sub forces the initial carry to one.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            out    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
        end else if (step) begin
            a_sh   <= a_sh >> DIGIT;
            b_sh   <= b_sh >> DIGIT;
            res_sh <= res_nxt;
            carry  <= slice_cout;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                out  <= res_nxt;
                cout <= slice_cout;
                ovf  <= slice_cmsb ^ slice_cout;
            end
        end
    end

endmodule

// File: tb/tb_add_serial.sv
// Directed bench for add_serial (WIDTH=16, DIGIT=4): vector table plus
// hand-written sequences for mid-run restart, reset and back-to-back use.
module tb_add_serial;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] out;
    logic        cout;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] out;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];
    vec_t held[4];

    always #5 clk = ~clk;

    add_serial #(
        .WIDTH (16),
        .DIGIT (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .sub     (sub),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .out     (out),
        .cout    (cout),
        .ovf     (ovf)
    );

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        int busy_cnt;
        int done_at;
        busy_cnt = 0;
        done_at  = 0;
        @(negedge clk);
        a     = v.a;
        b     = v.b;
        sub   = v.sub;
        cin   = v.cin;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        sub   = 1'($urandom);
        cin   = 1'($urandom);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_at = n;
                break;
            end
        end
        checkOutput({tag, ".busy_cycles"}, busy_cnt, 4);
        checkOutput({tag, ".done_edge"}, done_at, 5);
        checkOutput({tag, ".out"}, out, v.out);
        checkOutput({tag, ".cout"}, cout, v.cout);
        checkOutput({tag, ".ovf"}, ovf, v.ovf);
        @(negedge clk);
        checkOutput({tag, ".done_pulse"}, done, 1'b0);
        checkOutput({tag, ".out_hold"}, out, v.out);
    endtask

    initial begin
        int dones;
        int idx;
        int last_done;
        bit prev_done;
        logic [15:0] seen_out;

        vecs[0] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[8] = '{16'hABCD, 16'h1234, 1'b0, 1'b1, 16'hBE02, 1'b0, 1'b0};
        vecs[9] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};

        held[0] = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0};
        held[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0};
        held[2] = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        held[3] = '{16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};

        reset_n = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        sub     = 1'b0;
        cin     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.busy", busy, 1'b0);
        checkOutput("reset.done", done, 1'b0);
        checkOutput("reset.out", out, 16'h0000);
        checkOutput("reset.cout", cout, 1'b0);
        checkOutput("reset.ovf", ovf, 1'b0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Restart attempt mid-run must be ignored.
        @(negedge clk);
        a = 16'h0100; b = 16'h0200; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        seen_out = '0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                seen_out = out;
            end
        end
        checkOutput("norestart.done_count", dones, 1);
        checkOutput("norestart.out", seen_out, 16'h0300);

        // Reset sampled at the edge ending the second RUN cycle.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("midreset.busy", busy, 1'b0);
        checkOutput("midreset.done", done, 1'b0);
        checkOutput("midreset.out", out, 16'h0000);
        reset_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checkOutput("midreset.no_done", dones, 0);
        applyStimulus(vecs[0], "after_reset");

        // Reset wins over a simultaneous start.
        @(negedge clk);
        reset_n = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        checkOutput("prio.busy", busy, 1'b0);
        checkOutput("prio.out", out, 16'h0000);
        start   = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("prio.still_idle", busy, 1'b0);

        // Start held high: each result comes from operands at its accept edge.
        @(negedge clk);
        a = held[0].a; b = held[0].b; sub = held[0].sub; cin = held[0].cin;
        start = 1'b1;
        idx = 0;
        last_done = 0;
        prev_done = 1'b1;
        for (int cyc = 1; cyc <= 60 && idx < 4; cyc++) begin
            @(negedge clk);
            if (done) begin
                checkOutput($sformatf("held%0d.out", idx), out, held[idx].out);
                checkOutput($sformatf("held%0d.cout", idx), cout, held[idx].cout);
                checkOutput($sformatf("held%0d.ovf", idx), ovf, held[idx].ovf);
                checkOutput($sformatf("held%0d.interval", idx), cyc - last_done, 5);
                last_done = cyc;
                idx++;
                if (idx < 4) begin
                    a = held[idx].a; b = held[idx].b;
                    sub = held[idx].sub; cin = held[idx].cin;
                end else begin
                    start = 1'b0;
                end
                prev_done = 1'b1;
            end else begin
                if (prev_done) begin
                    a   = 16'($urandom);
                    b   = 16'($urandom);
                    sub = 1'($urandom);
                    cin = 1'($urandom);
                end
                prev_done = 1'b0;
            end
        end
        start = 1'b0;
        checkOutput("held.results", idx, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
